// File: rtl/accum_pkg.sv
// Shared types and helpers for the pushbutton-driven 8-bit accumulator.
// Holds the accumulator width, the key debouncer state type and the add helper.
package accum_pkg;

    localparam int ACC_W = 8;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_e;

    typedef struct packed {
        logic [ACC_W-1:0] value;
        logic             carry;
    } acc_result_t;

    // Unsigned add that keeps the carry-out alongside the wrapped sum.
    function automatic acc_result_t acc_add(input logic [ACC_W-1:0] a,
                                            input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        acc_result_t    res;
        sum       = {1'b0, a} + {1'b0, b};
        res.value = sum[ACC_W-1:0];
        res.carry = sum[ACC_W];
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one raw active-low pushbutton: 2-flop synchronizer, stability
// counter and four-state FSM emitting a single-cycle pulse per accepted press.
module key_debounce
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    key_state_e       state;
    key_state_e       state_nxt;
    logic             stable_level;
    logic             mismatch;
    logic             done;
    logic             press_nxt;

    // NOTE: every flop here uses <= so all registers sample pre-edge values;
    // blocking assignments would let sync2 see this edge's sync1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            state <= RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
        end
    end

    // The accepted level is implied by which half of the FSM we are in.
    assign stable_level = (state == PRESSED || state == RELEASE_WAIT) ? 1'b0 : 1'b1;
    assign mismatch     = (sync2 != stable_level);
    assign done         = mismatch && (cnt == CNT_MAX);

    // NOTE: outputs of this block get defaults first so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (mismatch && !done) ? cnt + 1'b1 : '0;
        unique case (state)
            RELEASED:     if (mismatch) state_nxt = done ? PRESSED : PRESS_WAIT;
            PRESS_WAIT:   if (!mismatch) state_nxt = RELEASED;
                          else if (done) state_nxt = PRESSED;
            PRESSED:      if (mismatch) state_nxt = done ? RELEASED : RELEASE_WAIT;
            RELEASE_WAIT: if (!mismatch) state_nxt = PRESSED;
                          else if (done) state_nxt = RELEASED;
            default:      state_nxt = RELEASED;
        endcase
        press_nxt = (state == RELEASED || state == PRESS_WAIT) && (state_nxt == PRESSED);
    end

endmodule

// File: rtl/accum_ctrl.sv
// Pushbutton accumulator: debounced clear/accumulate keys drive an 8-bit total.
// Define ACCUM_SATURATE_EN to clamp at 255 on carry-out instead of wrapping.
module accum_ctrl
    import accum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             clear_n,
    input  logic             accumulate_n,
    input  logic [ACC_W-1:0] switch,
    output logic [ACC_W-1:0] led_out,
    output logic             overflow,
    output logic             update
);

    logic             clear_evt;
    logic             acc_evt;
    logic             clear_q;
    logic             acc_q;
    logic [ACC_W-1:0] addend_q;
    acc_result_t      sum;
    logic [ACC_W-1:0] acc_value;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .key_n (clear_n),
        .press (clear_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_db (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .key_n (accumulate_n),
        .press (acc_evt)
    );

    always_comb begin
        sum = acc_add(led_out, addend_q);
`ifdef ACCUM_SATURATE_EN
        acc_value = sum.carry ? {ACC_W{1'b1}} : sum.value;
`else
        acc_value = sum.value;
`endif
    end

    // Events and the switch value are captured together so the addend is the
    // one present in the event cycle; the total then updates one cycle later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clear_q  <= 1'b0;
            acc_q    <= 1'b0;
            addend_q <= '0;
            led_out  <= '0;
            overflow <= 1'b0;
            update   <= 1'b0;
        end else begin
            clear_q  <= clear_evt;
            acc_q    <= acc_evt;
            addend_q <= switch;
            update   <= 1'b0;
            if (clear_q) begin
                led_out  <= '0;
                overflow <= 1'b0;
                update   <= 1'b1;
            end else if (acc_q) begin
                led_out  <= acc_value;
                overflow <= overflow | sum.carry;
                update   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl with a short debounce window.
// Expected totals follow the ACCUM_SATURATE_EN setting of the build.
module tb_accum_ctrl;

    localparam int DB = 8;
    localparam int LAT = DB + 3;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       clear_n = 1'b1;
    logic       accumulate_n = 1'b1;
    logic [7:0] switch = 8'h00;
    logic [7:0] led_out;
    logic       overflow;
    logic       update;

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    typedef struct {
        bit         use_clear;
        logic [7:0] sw;
        logic [7:0] exp_led;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[9];

    accum_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .clear_n       (clear_n),
        .accumulate_n  (accumulate_n),
        .switch        (switch),
        .led_out       (led_out),
        .overflow      (overflow),
        .update        (update)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock, then settle just after the edge; tallies update pulses.
    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (update) upd_cnt++;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input bit use_clear, input bit use_acc, input logic [7:0] sw);
        switch = sw;
        if (use_clear) clear_n = 1'b0;
        if (use_acc) accumulate_n = 1'b0;
        upd_cnt = 0;
        wait_ticks(20);
        clear_n = 1'b1;
        accumulate_n = 1'b1;
        wait_ticks(15);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h05, 8'h05, 1'b0};
        vecs[1] = '{1'b0, 8'h05, 8'h0A, 1'b0};
        vecs[2] = '{1'b0, 8'h05, 8'h0F, 1'b0};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'hF0, 8'hF0, 1'b0};
`ifdef ACCUM_SATURATE_EN
        vecs[5] = '{1'b0, 8'h20, 8'hFF, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 8'hFF, 1'b1};
`else
        vecs[5] = '{1'b0, 8'h20, 8'h10, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 8'h10, 1'b1};
`endif
        vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{1'b0, 8'h33, 8'h33, 1'b0};

        #2;
        check("reset_led", 32'(led_out), 32'h00);
        check("reset_ovf", 32'(overflow), 32'h0);
        check("reset_update", 32'(update), 32'h0);
        wait_ticks(3);
        reset_reset_n = 1'b1;
        wait_ticks(3);

        for (int v = 0; v < 9; v++) begin
            press(vecs[v].use_clear, !vecs[v].use_clear, vecs[v].sw);
            check($sformatf("vec%0d_led", v), 32'(led_out), 32'(vecs[v].exp_led));
            check($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_updates", v), 32'(upd_cnt), 32'd1);
        end

        // Both keys complete together from 0x33: clear wins.
        press(1'b1, 1'b1, 8'h44);
        check("both_led", 32'(led_out), 32'h00);
        check("both_ovf", 32'(overflow), 32'h0);
        check("both_updates", 32'(upd_cnt), 32'd1);

        // Bouncing shorter than the window, then a clean hold.
        switch = 8'h01;
        upd_cnt = 0;
        for (int r = 0; r < 4; r++) begin
            accumulate_n = 1'b0;
            wait_ticks(5);
            accumulate_n = 1'b1;
            wait_ticks(2);
        end
        check("bounce_no_event", 32'(upd_cnt), 32'd0);
        accumulate_n = 1'b0;
        wait_ticks(LAT);
        check("bounce_led_before", 32'(led_out), 32'h00);
        tick();
        check("bounce_led_at_lat", 32'(led_out), 32'h01);
        check("bounce_update_at_lat", 32'(update), 32'h1);
        wait_ticks(40 - LAT - 1);
        accumulate_n = 1'b1;
        wait_ticks(15);
        check("bounce_updates", 32'(upd_cnt), 32'd1);

        // Long hold then release: one event only.
        switch = 8'h02;
        upd_cnt = 0;
        accumulate_n = 1'b0;
        wait_ticks(100);
        check("hold_updates", 32'(upd_cnt), 32'd1);
        check("hold_led", 32'(led_out), 32'h03);
        accumulate_n = 1'b1;
        wait_ticks(20);
        check("release_no_event", 32'(upd_cnt), 32'd1);
        check("release_led", 32'(led_out), 32'h03);

        // Reset in the middle of PRESS_WAIT with the key still held.
        switch = 8'h04;
        accumulate_n = 1'b0;
        wait_ticks(6);
        reset_reset_n = 1'b0;
        #1;
        check("midreset_led", 32'(led_out), 32'h00);
        check("midreset_ovf", 32'(overflow), 32'h0);
        check("midreset_update", 32'(update), 32'h0);
        wait_ticks(2);
        reset_reset_n = 1'b1;
        upd_cnt = 0;
        wait_ticks(LAT);
        check("postreset_led_before", 32'(led_out), 32'h00);
        tick();
        check("postreset_led_at_lat", 32'(led_out), 32'h04);
        check("postreset_update_at_lat", 32'(update), 32'h1);
        wait_ticks(10);
        accumulate_n = 1'b1;
        wait_ticks(15);
        check("postreset_updates", 32'(upd_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
